// File: rtl/vc_sched_pkg.sv
// Shared definitions for the VC-to-destination scheduler.
// Provides the FSM state encoding, the default destination-bit position and
// the weight clamp used when loading the round-robin credit.
package vc_sched_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SERVE = 1'b1;

  typedef enum logic {
    StIdle  = ST_IDLE,
    StServe = ST_SERVE
  } sched_state_e;

  // Destination select sits one below the MSB of the default 6-bit word.
  localparam int unsigned DATA_WIDTH_DFLT = 6;
  localparam int unsigned DEST_BIT        = DATA_WIDTH_DFLT - 2;

  // A zero weight would starve its VC, so it is promoted to one pop per round.
  function automatic int unsigned w_clamp(input int unsigned weight);
    return (weight == 0) ? 1 : weight;
  endfunction

endpackage

// File: rtl/wrr_credit_counter.sv
// Credit counter and owner bit for a two-way weighted round-robin.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   start            load owner=0, credit=w_vc0 (entering service)
//   take_cur         owner was granted this cycle
//   take_other       non-owner was granted this cycle
//   w_vc0, w_vc1     clamped (non-zero) weights, sampled only on a load
//   owner            VC currently holding credit
//   credit           remaining pops for the owner
//   zero             credit is zero (only outside service)
module wrr_credit_counter #(
  parameter int unsigned WEIGHT_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    take_cur,
  input  logic                    take_other,
  input  logic [WEIGHT_WIDTH-1:0] w_vc0,
  input  logic [WEIGHT_WIDTH-1:0] w_vc1,
  output logic                    owner,
  output logic [WEIGHT_WIDTH-1:0] credit,
  output logic                    zero
);

  logic                    owner_q, owner_d;
  logic [WEIGHT_WIDTH-1:0] credit_q, credit_d;
  logic [WEIGHT_WIDTH-1:0] w_own, w_oth, dec_own, dec_oth;

  always_comb begin
    owner_d  = owner_q;
    credit_d = credit_q;
    w_own    = owner_q ? w_vc1 : w_vc0;
    w_oth    = owner_q ? w_vc0 : w_vc1;
    dec_own  = credit_q - WEIGHT_WIDTH'(1);
    dec_oth  = w_oth - WEIGHT_WIDTH'(1);
    if (start) begin
      owner_d  = 1'b0;
      credit_d = w_vc0;
    end else if (take_cur) begin
      if (dec_own == '0) begin
        owner_d  = ~owner_q;
        credit_d = w_oth;
      end else begin
        credit_d = dec_own;
      end
    end else if (take_other) begin
      // Other VC steals the turn; a weight-1 steal hands it straight back.
      if (dec_oth == '0) begin
        credit_d = w_own;
      end else begin
        owner_d  = ~owner_q;
        credit_d = dec_oth;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q  <= 1'b0;
      credit_q <= '0;
    end else begin
      owner_q  <= owner_d;
      credit_q <= credit_d;
    end
  end

  assign owner  = owner_q;
  assign credit = credit_q;
  assign zero   = (credit_q == '0);

endmodule

// File: rtl/vc_dest_scheduler.sv
// Weighted round-robin scheduler from the VC0/VC1 FIFOs to the D0/D1 FIFOs.
// Pops at most one eligible head word per cycle and pushes it, one cycle
// later, to the D FIFO chosen by the word's destination bit.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   init                       enable; 0 returns the FSM to IDLE
//   weight_vc0, weight_vc1     consecutive-pop budgets (0 treated as 1)
//   vcX_data, vcX_empty        first-word-fall-through VC FIFO heads
//   d0/d1_almost_full          destination backpressure, checked at pop time
//   vc0_pop, vc1_pop           combinational pops
//   d_data, d0_push, d1_push   registered word and one-cycle push strobes
//   cur_vc, active             credit owner, FSM not in IDLE
//   cnt_d0, cnt_d1             wrapping delivered-word counters
module vc_dest_scheduler
  import vc_sched_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 6,
  parameter int unsigned WEIGHT_WIDTH = 4,
  parameter int unsigned CNT_WIDTH    = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    init,
  input  logic [WEIGHT_WIDTH-1:0] weight_vc0,
  input  logic [WEIGHT_WIDTH-1:0] weight_vc1,
  input  logic [DATA_WIDTH-1:0]   vc0_data,
  input  logic                    vc0_empty,
  input  logic [DATA_WIDTH-1:0]   vc1_data,
  input  logic                    vc1_empty,
  input  logic                    d0_almost_full,
  input  logic                    d1_almost_full,
  output logic                    vc0_pop,
  output logic                    vc1_pop,
  output logic [DATA_WIDTH-1:0]   d_data,
  output logic                    d0_push,
  output logic                    d1_push,
  output logic                    cur_vc,
  output logic                    active,
  output logic [CNT_WIDTH-1:0]    cnt_d0,
  output logic [CNT_WIDTH-1:0]    cnt_d1
);

  localparam int unsigned DestBit = DATA_WIDTH - 2;

  sched_state_e            state_q, state_d;
  logic [WEIGHT_WIDTH-1:0] w0, w1, credit;
  logic                    e0, e1, e_cur, e_oth, serve, start, take_cur, take_other;
  logic                    credit_zero;
  logic [DATA_WIDTH-1:0]   pop_word;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    push0_q, push1_q;
  logic [CNT_WIDTH-1:0]    cnt_d0_q, cnt_d1_q;

  assign w0 = WEIGHT_WIDTH'(w_clamp(32'(weight_vc0)));
  assign w1 = WEIGHT_WIDTH'(w_clamp(32'(weight_vc1)));

  assign e0 = ~vc0_empty & ~(vc0_data[DestBit] ? d1_almost_full : d0_almost_full);
  assign e1 = ~vc1_empty & ~(vc1_data[DestBit] ? d1_almost_full : d0_almost_full);

  // Pops are suppressed while reset is high so no word is lost to the reset.
  assign serve      = (state_q == StServe) & init & ~reset;
  assign start      = (state_q == StIdle) & init & ~reset;
  assign e_cur      = cur_vc ? e1 : e0;
  assign e_oth      = cur_vc ? e0 : e1;
  assign take_cur   = serve & e_cur;
  assign take_other = serve & ~e_cur & e_oth;

  assign vc0_pop  = (take_cur & ~cur_vc) | (take_other & cur_vc);
  assign vc1_pop  = (take_cur & cur_vc) | (take_other & ~cur_vc);
  assign pop_word = vc1_pop ? vc1_data : vc0_data;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (init) state_d = StServe;
      StServe: if (!init) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      data_q   <= '0;
      push0_q  <= 1'b0;
      push1_q  <= 1'b0;
      cnt_d0_q <= '0;
      cnt_d1_q <= '0;
    end else begin
      state_q <= state_d;
      if (vc0_pop || vc1_pop) begin
        data_q  <= pop_word;
        push0_q <= ~pop_word[DestBit];
        push1_q <= pop_word[DestBit];
      end else begin
        push0_q <= 1'b0;
        push1_q <= 1'b0;
      end
      if (push0_q) cnt_d0_q <= cnt_d0_q + CNT_WIDTH'(1);
      if (push1_q) cnt_d1_q <= cnt_d1_q + CNT_WIDTH'(1);
    end
  end

  wrr_credit_counter #(
    .WEIGHT_WIDTH(WEIGHT_WIDTH)
  ) u_credit (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .take_cur  (take_cur),
    .take_other(take_other),
    .w_vc0     (w0),
    .w_vc1     (w1),
    .owner     (cur_vc),
    .credit    (credit),
    .zero      (credit_zero)
  );

  // A push still pending when reset rises is dropped, not delivered.
  assign d0_push = push0_q & ~reset;
  assign d1_push = push1_q & ~reset;
  assign d_data  = data_q;
  assign active  = (state_q == StServe);
  assign cnt_d0  = cnt_d0_q;
  assign cnt_d1  = cnt_d1_q;

endmodule

// File: tb/tb_vc_dest_scheduler.sv
// Scoreboard bench for vc_dest_scheduler: the stimulus process checks pops
// and queues the expected push; a monitor compares every push it sees.
module tb_vc_dest_scheduler;

  logic       clk = 1'b0;
  logic       reset, init;
  logic [3:0] weight_vc0, weight_vc1;
  logic [5:0] vc0_data, vc1_data;
  logic       vc0_empty, vc1_empty, d0_almost_full, d1_almost_full;
  logic       vc0_pop, vc1_pop, d0_push, d1_push, cur_vc, active;
  logic [5:0] d_data;
  logic [7:0] cnt_d0, cnt_d1;

  typedef struct packed {
    logic       d1;
    logic [5:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  vc_dest_scheduler dut (
    .clk           (clk),
    .reset         (reset),
    .init          (init),
    .weight_vc0    (weight_vc0),
    .weight_vc1    (weight_vc1),
    .vc0_data      (vc0_data),
    .vc0_empty     (vc0_empty),
    .vc1_data      (vc1_data),
    .vc1_empty     (vc1_empty),
    .d0_almost_full(d0_almost_full),
    .d1_almost_full(d1_almost_full),
    .vc0_pop       (vc0_pop),
    .vc1_pop       (vc1_pop),
    .d_data        (d_data),
    .d0_push       (d0_push),
    .d1_push       (d1_push),
    .cur_vc        (cur_vc),
    .active        (active),
    .cnt_d0        (cnt_d0),
    .cnt_d1        (cnt_d1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check pops in the current cycle, queue the push they imply, advance.
  task automatic expect_pop(input string name, input logic p0, input logic p1);
    @(negedge clk);
    chk({name, ".vc0_pop"}, 32'(vc0_pop), 32'(p0));
    chk({name, ".vc1_pop"}, 32'(vc1_pop), 32'(p1));
    if (p0) exp_q.push_back({vc0_data[4], vc0_data});
    if (p1) exp_q.push_back({vc1_data[4], vc1_data});
    tick();
  endtask

  always @(negedge clk) begin
    if (d0_push || d1_push) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL push_unexpected: got d0=%0b d1=%0b data=%0h, expected no push",
                 d0_push, d1_push, d_data);
      end else begin
        mon_e = exp_q.pop_front();
        if ({d1_push, d0_push, d_data} !== {mon_e.d1, ~mon_e.d1, mon_e.data}) begin
          fails++;
          $display("FAIL push_data: got d0=%0b d1=%0b data=%0h, expected d1=%0b data=%0h",
                   d0_push, d1_push, d_data, mon_e.d1, mon_e.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] pat31;
    logic [5:0] pat21;
    pat31 = 8'b01110111;
    pat21 = 6'b011011;

    reset = 1'b1; init = 1'b0;
    weight_vc0 = 4'd3; weight_vc1 = 4'd1;
    vc0_data = 6'b000011; vc1_data = 6'b000111;
    vc0_empty = 1'b0; vc1_empty = 1'b0;
    d0_almost_full = 1'b0; d1_almost_full = 1'b0;

    // Reset and idle with both VCs non-empty.
    repeat (2) tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst.vc0_pop", 32'(vc0_pop), 0);
    chk("rst.vc1_pop", 32'(vc1_pop), 0);
    chk("rst.d0_push", 32'(d0_push), 0);
    chk("rst.d1_push", 32'(d1_push), 0);
    chk("rst.d_data", 32'(d_data), 0);
    chk("rst.active", 32'(active), 0);
    chk("rst.cur_vc", 32'(cur_vc), 0);
    chk("rst.cnt_d0", 32'(cnt_d0), 0);
    chk("rst.cnt_d1", 32'(cnt_d1), 0);
    tick();

    // Weights 3/1: VC0,VC0,VC0,VC1 repeating.
    init = 1'b1;
    expect_pop("idle_wait", 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) expect_pop("wrr31", pat31[i], ~pat31[i]);
    init = 1'b0;
    expect_pop("init_fall", 1'b0, 1'b0);
    @(negedge clk);
    chk("wrr31.cnt_d0", 32'(cnt_d0), 8);
    chk("wrr31.active", 32'(active), 0);
    tick();

    // VC0 empty: VC1 popped, cur_vc moves to 1.
    vc0_empty = 1'b1; vc1_data = 6'b010101;
    weight_vc0 = 4'd2; weight_vc1 = 4'd2;
    init = 1'b1;
    expect_pop("t3_idle", 1'b0, 1'b0);
    expect_pop("t3_vc1", 1'b0, 1'b1);
    vc1_empty = 1'b1;
    @(negedge clk);
    chk("t3.d_data", 32'(d_data), 32'h15);
    chk("t3.d1_push", 32'(d1_push), 1);
    chk("t3.cur_vc", 32'(cur_vc), 1);
    tick();
    @(negedge clk);
    chk("t3.cnt_d1", 32'(cnt_d1), 1);
    tick();

    // VC0 blocked by D1 almost full; VC1 carries on; VC0 resumes on release.
    vc0_data = 6'b010000; vc0_empty = 1'b0;
    vc1_data = 6'b000001; vc1_empty = 1'b0;
    d1_almost_full = 1'b1;
    repeat (3) expect_pop("t4_block", 1'b0, 1'b1);
    d1_almost_full = 1'b0;
    expect_pop("t4_resume", 1'b1, 1'b0);
    vc0_empty = 1'b1; vc1_empty = 1'b1;
    expect_pop("both_empty", 1'b0, 1'b0);
    @(negedge clk);
    chk("both_empty.active", 32'(active), 1);
    tick();
    vc0_empty = 1'b0; vc1_empty = 1'b0;
    d0_almost_full = 1'b1; d1_almost_full = 1'b1;
    expect_pop("both_af", 1'b0, 1'b0);
    d0_almost_full = 1'b0; d1_almost_full = 1'b0;
    vc0_empty = 1'b1; vc1_empty = 1'b1;

    // Weight 0 on VC1 acts as 1: VC0,VC0,VC1.
    weight_vc0 = 4'd2; weight_vc1 = 4'd0;
    init = 1'b0;
    expect_pop("t5_drop", 1'b0, 1'b0);
    init = 1'b1;
    vc0_data = 6'b000010; vc1_data = 6'b000100;
    vc0_empty = 1'b0; vc1_empty = 1'b0;
    expect_pop("t5_idle", 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) expect_pop("wrr20", pat21[i], ~pat21[i]);
    init = 1'b0;
    expect_pop("t5_fall", 1'b0, 1'b0);

    // Reset right after a pop drops the pending push.
    init = 1'b1; vc1_empty = 1'b1;
    expect_pop("t6_idle", 1'b0, 1'b0);
    @(negedge clk);
    chk("t6.vc0_pop", 32'(vc0_pop), 1);
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("t6.d0_push", 32'(d0_push), 0);
    chk("t6.d1_push", 32'(d1_push), 0);
    tick();
    reset = 1'b0; init = 1'b0;
    @(negedge clk);
    chk("t6.cnt_d0", 32'(cnt_d0), 0);
    chk("t6.cnt_d1", 32'(cnt_d1), 0);
    chk("t6.active", 32'(active), 0);
    chk("t6.d_data", 32'(d_data), 0);
    chk("t6.cur_vc", 32'(cur_vc), 0);
    tick();

    // Counter wrap: 255 D0 words, then one more.
    weight_vc0 = 4'd1; weight_vc1 = 4'd1;
    vc0_data = 6'b000011; vc0_empty = 1'b0; vc1_empty = 1'b1;
    init = 1'b1;
    expect_pop("t7_idle", 1'b0, 1'b0);
    repeat (255) begin
      exp_q.push_back({1'b0, vc0_data});
      tick();
    end
    vc0_empty = 1'b1;
    tick();
    @(negedge clk);
    chk("wrap.cnt_d0_255", 32'(cnt_d0), 255);
    tick();
    vc0_empty = 1'b0;
    expect_pop("wrap_last", 1'b1, 1'b0);
    vc0_empty = 1'b1;
    tick();
    @(negedge clk);
    chk("wrap.cnt_d0_0", 32'(cnt_d0), 0);
    tick();

    chk("scoreboard_drain", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
